dmem_sized: RTL and testbench
=============================

Name: dmem_sized

Overview:
- Parametrised data memory for the RISC-V core, successor to the flat word-array DMEM.
- Byte-addressed, with RV32I sized accesses: SB/SH/SW and LB/LH/LW/LBU/LHU, including per-byte write enables and load sign/zero extension.
- Detects misaligned, out-of-range and illegal-size accesses.
- Valid/ready request and response handshake with programmable read latency, so the core can later tolerate slower memories.

Parameters:
- DEPTH_WORDS, 1024, number of 32-bit words; must be a power of two, at least 4.
- READ_LAT, 1, cycles from request accept to rsp_valid; legal range 1..4.
- ADDR_W, 32, byte-address width.

Ports:
- clk  in  1  rising-edge clock
- rst_n  in  1  asynchronous active-low reset
- req_valid  in  1  request present
- req_ready  out  1  block can accept a request
- req_write  in  1  1 = store, 0 = load
- req_size  in  3  funct3 encoding: 000 B, 001 H, 010 W, 100 BU, 101 HU
- req_addr  in  ADDR_W  byte address
- req_wdata  in  32  store data, right-justified
- rsp_valid  out  1  response available
- rsp_ready  in  1  consumer takes the response
- rsp_rdata  out  32  extended load data; 0 for stores and errors
- rsp_err  out  1  access faulted

Behaviour:
- Reset (rst_n=0, asynchronous):
  - State goes to IDLE.
  - req_ready=1, rsp_valid=0, rsp_rdata=0, rsp_err=0, latency counter=0.
  - Memory array is NOT reset.
- States:
  - IDLE: req_ready=1. On req_valid, the request is accepted at that clock edge.
    - READ_LAT=1: go to RESP.
    - Otherwise: go to WAIT with counter=READ_LAT-2.
  - WAIT: req_ready=0. Counter decrements each cycle; at 0, go to RESP.
  - RESP: rsp_valid=1 and rsp_rdata/rsp_err are held stable. When rsp_ready=1, return to IDLE next cycle.
- Single outstanding request. req_ready=1 only in IDLE. Maximum throughput is 1 request per READ_LAT+1 cycles with rsp_ready tied high.
- Address decode:
  - Word index = req_addr[log2(DEPTH_WORDS)+1:2].
  - Byte lane = req_addr[1:0].
- Fault checks, evaluated at accept. Any fault sets rsp_err=1 and rsp_rdata=0, and blocks the memory write.
  - Range: req_addr >= DEPTH_WORDS*4.
  - Halfword misalign: size H/HU with addr[0]=1.
  - Word misalign: size W with addr[1:0]!=0.
  - Illegal size: size 011, 110 or 111, for either load or store.
  - Illegal size for store: size 100 or 101 with req_write=1.
- Stores:
  - Commit at the accept edge using byte enables. B enables lane addr[1:0]; H enables lanes {addr[1],0} and {addr[1],1}; W enables all 4 lanes.
  - Write data is replicated into the selected lanes. Other bytes are unchanged.
  - Response: rsp_err as above, rsp_rdata=0.
- Loads:
  - The word is read and the selected byte/half extracted at the accept edge, then registered and delayed.
  - B and H sign-extend from bit 7 or bit 15; BU and HU zero-extend; W passes through.
- Ordering: a load following a store to the same address returns the stored value. This holds because the store has committed before its response.
- Reset mid-operation: a pending response is dropped and no rsp_valid is issued. A store accepted before reset stays committed.
- req_* inputs are ignored outside IDLE. rsp_ready is ignored outside RESP.

Test Plan:
- Reset, then SW addr 0x10, wdata 0xDEADBEEF; then LW 0x10 with READ_LAT=1 -> rsp_valid exactly 1 cycle after each accept; load returns rdata 0xDEADBEEF, err 0.
- After the above, SB addr 0x11, wdata 0x000000A5; then LB 0x11 -> 0xFFFFFFA5; LBU 0x11 -> 0x000000A5; LW 0x10 -> 0xDEADA5EF.
- SH addr 0x22, wdata 0x8001; then LH 0x22 -> 0xFFFF8001; LHU 0x22 -> 0x00008001; LW 0x20 -> 0x8001xxxx with the lower half unchanged from prior contents.
- Faults:
  - LW 0x13 -> err=1, rdata=0.
  - SH 0x21 -> err=1, and a following LW 0x20 is unchanged.
  - LW 0x1000 with DEPTH_WORDS=1024 -> err=1.
  - size 011 -> err=1.
- READ_LAT=3 with rsp_ready held low 5 cycles -> rsp_valid rises 3 cycles after accept and holds stable with req_ready=0 throughout; on rsp_ready=1, IDLE follows next cycle.
- Assert rst_n=0 in WAIT during LW with READ_LAT=4 -> outputs immediately return to reset values; no rsp_valid follows. A store accepted before reset reads back its value after reset.

Source files
------------

// File: rtl/dmem_sized.sv
// Byte-addressed RV32I data memory with sized loads/stores, fault detection
// and a valid/ready handshake with programmable read latency.
//
// state  | meaning
// S_IDLE | ready for a request; accept commits stores and captures load data
// S_WAIT | counting down the remaining read latency
// S_RESP | response presented, held until rsp_ready
module dmem_sized #(
  parameter int DEPTH_WORDS = 1024,
  parameter int READ_LAT    = 1,
  parameter int ADDR_W      = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic              req_write,
  input  logic [2:0]        req_size,
  input  logic [ADDR_W-1:0] req_addr,
  input  logic [31:0]       req_wdata,
  output logic              rsp_valid,
  input  logic              rsp_ready,
  output logic [31:0]       rsp_rdata,
  output logic              rsp_err
);

  localparam int IDX_W = $clog2(DEPTH_WORDS);
  localparam logic [1:0] CNT_INIT = (READ_LAT >= 2) ? 2'(READ_LAT - 2) : 2'd0;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_RESP} state_t;

  state_t      state;
  logic [1:0]  cnt;
  logic [31:0] mem [DEPTH_WORDS];

  logic [IDX_W-1:0] idx;
  logic [1:0]       lane;
  logic             accept;
  logic             out_of_range;
  logic             bad_size;
  logic             misalign;
  logic             fault;
  logic [3:0]       byte_en;
  logic [31:0]      wdata_rep;
  logic [31:0]      word;
  logic [7:0]       sel_byte;
  logic [15:0]      sel_half;
  logic [31:0]      load_data;

  assign idx    = req_addr[IDX_W+1:2];
  assign lane   = req_addr[1:0];
  assign accept = (state == S_IDLE) && req_valid;
  assign word   = mem[idx];

  assign out_of_range = (req_addr >> (IDX_W + 2)) != '0;

  always_comb begin
    bad_size = 1'b0;
    misalign = 1'b0;
    case (req_size)
      3'b000: ;
      3'b001: misalign = lane[0];
      3'b010: misalign = (lane != 2'b00);
      3'b100: bad_size = req_write;
      3'b101: begin
        bad_size = req_write;
        misalign = lane[0];
      end
      default: bad_size = 1'b1;
    endcase
  end

  assign fault = out_of_range || bad_size || misalign;

  always_comb begin
    byte_en   = 4'b0000;
    wdata_rep = req_wdata;
    case (req_size)
      3'b000: begin
        byte_en   = 4'b0001 << lane;
        wdata_rep = {4{req_wdata[7:0]}};
      end
      3'b001: begin
        byte_en   = lane[1] ? 4'b1100 : 4'b0011;
        wdata_rep = {2{req_wdata[15:0]}};
      end
      3'b010: byte_en = 4'b1111;
      default: byte_en = 4'b0000;
    endcase
  end

  always_comb begin
    sel_byte = word[7:0];
    case (lane)
      2'd0: sel_byte = word[7:0];
      2'd1: sel_byte = word[15:8];
      2'd2: sel_byte = word[23:16];
      2'd3: sel_byte = word[31:24];
      default: sel_byte = word[7:0];
    endcase
  end

  assign sel_half = lane[1] ? word[31:16] : word[15:0];

  always_comb begin
    load_data = 32'd0;
    case (req_size)
      3'b000: load_data = {{24{sel_byte[7]}}, sel_byte};
      3'b001: load_data = {{16{sel_half[15]}}, sel_half};
      3'b010: load_data = word;
      3'b100: load_data = {24'd0, sel_byte};
      3'b101: load_data = {16'd0, sel_half};
      default: load_data = 32'd0;
    endcase
  end

  // Stores commit at the accept edge, so a later load always sees them.
  always_ff @(posedge clk) begin
    if (rst_n && accept && req_write && !fault) begin
      for (int b = 0; b < 4; b++) begin
        if (byte_en[b]) mem[idx][b*8 +: 8] <= wdata_rep[b*8 +: 8];
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= S_IDLE;
      cnt       <= 2'd0;
      req_ready <= 1'b1;
      rsp_valid <= 1'b0;
      rsp_rdata <= 32'd0;
      rsp_err   <= 1'b0;
    end else begin
      case (state)
        S_IDLE: begin
          if (req_valid) begin
            req_ready <= 1'b0;
            rsp_err   <= fault;
            rsp_rdata <= (fault || req_write) ? 32'd0 : load_data;
            if (READ_LAT == 1) begin
              state     <= S_RESP;
              rsp_valid <= 1'b1;
            end else begin
              state <= S_WAIT;
              cnt   <= CNT_INIT;
            end
          end
        end
        S_WAIT: begin
          if (cnt == 2'd0) begin
            state     <= S_RESP;
            rsp_valid <= 1'b1;
          end else begin
            cnt <= cnt - 2'd1;
          end
        end
        S_RESP: begin
          if (rsp_ready) begin
            state     <= S_IDLE;
            req_ready <= 1'b1;
            rsp_valid <= 1'b0;
            rsp_rdata <= 32'd0;
            rsp_err   <= 1'b0;
          end
        end
        default: begin
          state     <= S_IDLE;
          req_ready <= 1'b1;
          rsp_valid <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_dmem_sized.sv
// Bench for dmem_sized: three instances (READ_LAT 1, 3, 4) checked against a
// byte-array memory model, with directed cases plus random traffic.
module tb_dmem_sized;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req_valid [3];
  logic        req_ready [3];
  logic        req_write [3];
  logic [2:0]  req_size  [3];
  logic [31:0] req_addr  [3];
  logic [31:0] req_wdata [3];
  logic        rsp_valid [3];
  logic        rsp_ready [3];
  logic [31:0] rsp_rdata [3];
  logic        rsp_err   [3];

  int checks = 0;
  int errors = 0;
  int lat_of [3] = '{1, 3, 4};
  logic [7:0] mdl [3][256];

  always #5 clk = ~clk;

  for (genvar g = 0; g < 3; g++) begin : g_dut
    localparam int LAT = (g == 0) ? 1 : ((g == 1) ? 3 : 4);
    dmem_sized #(.DEPTH_WORDS(1024), .READ_LAT(LAT), .ADDR_W(32)) u_dut (
      .clk       (clk),
      .rst_n     (rst_n),
      .req_valid (req_valid[g]),
      .req_ready (req_ready[g]),
      .req_write (req_write[g]),
      .req_size  (req_size[g]),
      .req_addr  (req_addr[g]),
      .req_wdata (req_wdata[g]),
      .rsp_valid (rsp_valid[g]),
      .rsp_ready (rsp_ready[g]),
      .rsp_rdata (rsp_rdata[g]),
      .rsp_err   (rsp_err[g])
    );
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  // Little-endian byte-array view of the RV32I access rules.
  task automatic model(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                       input logic [31:0] wd, output logic [31:0] rd, output logic err);
    int nb;
    logic [31:0] v;
    nb  = (sz[1:0] == 2'd0) ? 1 : ((sz[1:0] == 2'd1) ? 2 : 4);
    err = (sz == 3'd3) || (sz >= 3'd6) || (wr && sz >= 3'd4) ||
          (nb == 2 && addr % 2 != 0) || (nb == 4 && addr % 4 != 0) || (addr >= 32'd4096);
    rd = 32'd0;
    if (!err) begin
      if (wr) begin
        for (int i = 0; i < nb; i++) mdl[d][addr + i] = 8'((wd >> (8 * i)) & 32'hFF);
      end else begin
        v = 32'd0;
        for (int i = 0; i < nb; i++) v = v + (32'(mdl[d][addr + i]) << (8 * i));
        if (sz == 3'd0 && v >= 32'h80) v = v - 32'h100;
        if (sz == 3'd1 && v >= 32'h8000) v = v - 32'h10000;
        rd = v;
      end
    end
  endtask

  task automatic do_txn(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                        input logic [31:0] wd, input int hold,
                        output logic [31:0] obs_rd, output logic obs_err);
    logic [31:0] e_rd;
    logic        e_err;
    int          lat;
    model(d, wr, sz, addr, wd, e_rd, e_err);
    @(negedge clk);
    chk("ready_before_req", 32'(req_ready[d]), 32'd1);
    req_write[d] = wr;
    req_size[d]  = sz;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    rsp_ready[d] = 1'b0;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    lat = 1;
    while (!rsp_valid[d] && lat <= 10) begin
      if (req_ready[d] !== 1'b0) chk("ready_low_in_wait", 32'(req_ready[d]), 32'd0);
      @(posedge clk); #1;
      lat++;
    end
    chk("latency", 32'(lat), 32'(lat_of[d]));
    obs_rd  = rsp_rdata[d];
    obs_err = rsp_err[d];
    chk("rdata", obs_rd, e_rd);
    chk("err", 32'(obs_err), 32'(e_err));
    for (int i = 0; i < hold; i++) begin
      @(posedge clk); #1;
      chk("hold_valid", 32'(rsp_valid[d]), 32'd1);
      chk("hold_rdata", rsp_rdata[d], obs_rd);
      chk("hold_ready_low", 32'(req_ready[d]), 32'd0);
    end
    rsp_ready[d] = 1'b1;
    @(posedge clk); #1;
    rsp_ready[d] = 1'b0;
    chk("idle_after_rsp", {30'd0, rsp_valid[d], req_ready[d]}, 32'd1);
  endtask

  task automatic rst_mid(input int d, input bit wr, input logic [2:0] sz, input logic [31:0] addr,
                         input logic [31:0] wd);
    logic [31:0] e_rd;
    logic        e_err;
    bit          seen;
    model(d, wr, sz, addr, wd, e_rd, e_err);
    @(negedge clk);
    req_write[d] = wr;
    req_size[d]  = sz;
    req_addr[d]  = addr;
    req_wdata[d] = wd;
    req_valid[d] = 1'b1;
    @(posedge clk); #1;
    req_valid[d] = 1'b0;
    @(posedge clk); #1;
    chk("in_wait_ready", 32'(req_ready[d]), 32'd0);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {rsp_rdata[d][29:0], rsp_err[d], rsp_valid[d]}, 32'd0);
    chk("rst_mid_ready", 32'(req_ready[d]), 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    seen = 1'b0;
    for (int i = 0; i < 8; i++) begin
      @(posedge clk); #1;
      if (rsp_valid[d]) seen = 1'b1;
    end
    chk("no_rsp_after_rst", 32'(seen), 32'd0);
  endtask

  logic [31:0] rd;
  logic        er;
  logic [2:0]  legal [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd5};
  logic [2:0]  illeg [3] = '{3'd3, 3'd6, 3'd7};

  initial begin
    for (int d = 0; d < 3; d++) begin
      req_valid[d] = 1'b0; req_write[d] = 1'b0; req_size[d] = 3'd0;
      req_addr[d] = 32'd0; req_wdata[d] = 32'd0; rsp_ready[d] = 1'b0;
    end
    #22;
    for (int d = 0; d < 3; d++) begin
      chk("reset_ready", 32'(req_ready[d]), 32'd1);
      chk("reset_outputs", {rsp_rdata[d][29:0], rsp_err[d], rsp_valid[d]}, 32'd0);
    end
    @(negedge clk);
    rst_n = 1'b1;

    for (int d = 0; d < 3; d++)
      for (int w = 0; w < 64; w++) do_txn(d, 1'b1, 3'd2, 32'(w * 4), $urandom, 0, rd, er);

    do_txn(0, 1'b1, 3'd2, 32'h10, 32'hDEADBEEF, 0, rd, er);
    do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("lw_10", rd, 32'hDEADBEEF);
    do_txn(0, 1'b1, 3'd0, 32'h11, 32'h000000A5, 0, rd, er);
    do_txn(0, 1'b0, 3'd0, 32'h11, 32'h0, 0, rd, er);
    chk("lb_11", rd, 32'hFFFFFFA5);
    do_txn(0, 1'b0, 3'd4, 32'h11, 32'h0, 0, rd, er);
    chk("lbu_11", rd, 32'h000000A5);
    do_txn(0, 1'b0, 3'd2, 32'h10, 32'h0, 0, rd, er);
    chk("lw_10_after_sb", rd, 32'hDEADA5EF);
    do_txn(0, 1'b1, 3'd1, 32'h22, 32'h8001, 0, rd, er);
    do_txn(0, 1'b0, 3'd1, 32'h22, 32'h0, 0, rd, er);
    chk("lh_22", rd, 32'hFFFF8001);
    do_txn(0, 1'b0, 3'd5, 32'h22, 32'h0, 0, rd, er);
    chk("lhu_22", rd, 32'h00008001);
    do_txn(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
    chk("lw_20_upper", rd >> 16, 32'h8001);
    do_txn(0, 1'b0, 3'd2, 32'h13, 32'h0, 0, rd, er);
    chk("lw_13_err", {rd[30:0], er}, 32'd1);
    do_txn(0, 1'b1, 3'd1, 32'h21, 32'hFFFF, 0, rd, er);
    chk("sh_21_err", 32'(er), 32'd1);
    do_txn(0, 1'b0, 3'd2, 32'h20, 32'h0, 0, rd, er);
    do_txn(0, 1'b0, 3'd2, 32'h1000, 32'h0, 0, rd, er);
    chk("lw_1000_err", 32'(er), 32'd1);
    do_txn(0, 1'b0, 3'd3, 32'h20, 32'h0, 0, rd, er);
    chk("size3_err", 32'(er), 32'd1);

    do_txn(1, 1'b0, 3'd2, 32'h40, 32'h0, 5, rd, er);

    for (int d = 0; d < 3; d++) begin
      for (int n = 0; n < 60; n++) begin
        int r;
        logic [31:0] a;
        logic [2:0]  s;
        r = $urandom_range(0, 15);
        s = (r < 13) ? legal[r % 5] : illeg[r - 13];
        a = ($urandom_range(0, 9) == 0) ? $urandom_range(32'd4096, 32'hFFFFFFFF)
                                          : 32'($urandom_range(0, 252));
        do_txn(d, $urandom_range(0, 1) == 1, s, a, $urandom, 0, rd, er);
      end
    end

    rst_mid(2, 1'b0, 3'd2, 32'h40, 32'h0);
    rst_mid(2, 1'b1, 3'd2, 32'h44, 32'h5A5A1234);
    do_txn(2, 1'b0, 3'd2, 32'h44, 32'h0, 0, rd, er);
    chk("store_survives_rst", rd, 32'h5A5A1234);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
